// File: rtl/mem_writeback.sv
// mem_writeback: memory / write-back half of the three-stage pipeline.
// Issues loads and stores on a request/grant/response data bus. Formats
// load data, selects the register-file write-back value, and stalls the
// upstream stage while an access is outstanding.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with a one-cycle misalign pulse instead of issuing them.
module mem_writeback #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_ppl,
    input  logic [31:0] alu_ppl,
    input  logic [31:0] rdata2_ppl,
    input  logic [31:0] instruction_ppl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wdata,
    output logic        reg_wr,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign,
    output logic [1:0]  state_dbg
);
    // Bus handshake: dmem_req is held with stable addr/we/be/wdata until the
    // cycle in which dmem_gnt is seen high, which completes the request. A load
    // then receives exactly one response: the first dmem_rvalid at least one
    // cycle after its grant. dmem_rvalid outside WAIT is ignored.

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [1:0] off;
    assign opcode = instruction_ppl[6:2];
    assign funct3 = instruction_ppl[14:12];
    assign rd     = instruction_ppl[11:7];
    assign off    = alu_ppl[1:0];

    logic is_load, is_store, is_jump, is_branch;
    logic ld_ok, st_ok, mem_op, misaligned, writes_rd, timed_out;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign ld_ok     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_ok     = funct3 inside {3'b000, 3'b001, 3'b010};
    assign mem_op    = (is_load && ld_ok) || (is_store && st_ok);
    assign writes_rd = (rd != 5'd0) && !is_store && !is_branch;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

`ifdef MISALIGN_TRAP_EN
    // funct3[1:0]: 01 = halfword, 10 = word (same for loads and stores)
    assign misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                        ((funct3[1:0] == 2'b10) && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    logic [3:0]  be_lane;
    logic [31:0] st_data;
    // Store lane steering: replicate the datum across the word and enable its bytes.
    always_comb begin
        be_lane = 4'b1111;
        st_data = rdata2_ppl;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_lane = 4'b0001 << off;
                    st_data = {4{rdata2_ppl[7:0]}};
                end
                2'b01: begin
                    be_lane = 4'b0011 << {off[1], 1'b0};
                    st_data = {2{rdata2_ppl[15:0]}};
                end
                default: ;
            endcase
        end
    end

    logic [31:0] shifted;
    logic [31:0] ld_data;
    assign shifted = dmem_rdata >> {off, 3'b000};
    // Load formatting: extract the addressed byte/half and extend it.
    always_comb begin
        case (funct3)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    // State register and timeout counter; counter restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == S_IDLE)) cnt <= '0;
            else cnt <= cnt + CNT_W'(1);
        end
    end

    logic req_c, stall_c, wr_c, err_c, mis_c;
    // Next-state and handshake outputs; everything is forced low while in reset.
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        wr_c       = 1'b0;
        err_c      = 1'b0;
        mis_c      = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (mem_op && misaligned) begin
                        mis_c = 1'b1;
                    end else if (mem_op) begin
                        req_c = 1'b1;
                        if (!dmem_gnt) begin
                            state_next = S_REQ;
                            stall_c    = 1'b1;
                        end else if (is_load) begin
                            state_next = S_WAIT;
                            stall_c    = 1'b1;
                        end
                    end else begin
                        wr_c = writes_rd && !is_load;
                    end
                end
                S_REQ: begin
                    if (timed_out) begin
                        err_c      = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        req_c   = 1'b1;
                        stall_c = 1'b1;
                        if (dmem_gnt) begin
                            if (is_load) begin
                                state_next = S_WAIT;
                            end else begin
                                stall_c    = 1'b0;
                                state_next = S_IDLE;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (timed_out) begin
                        err_c      = 1'b1;
                        state_next = S_IDLE;
                    end else if (dmem_rvalid) begin
                        wr_c       = writes_rd;
                        state_next = S_IDLE;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign dmem_req   = req_c;
    assign dmem_we    = req_c && is_store;
    assign dmem_be    = req_c ? be_lane : 4'b0000;
    assign dmem_addr  = rst ? {alu_ppl[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = rst ? st_data : 32'd0;
    assign wdata      = !rst    ? 32'd0 :
                        is_jump ? pc_ppl + 32'd4 :
                        is_load ? ld_data : alu_ppl;
    assign reg_wr     = wr_c;
    assign stall      = stall_c;
    assign bus_err    = err_c;
    assign state_dbg  = state;

`ifdef MISALIGN_TRAP_EN
    assign misalign = mis_c;
`else
    logic unused_mis;
    assign unused_mis = mis_c;
    assign misalign   = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{instruction_ppl[31:15], instruction_ppl[1:0]};
endmodule

// File: tb/tb_mem_writeback.sv
// Testbench for mem_writeback: directed scenarios plus randomized load/store
// traffic checked against an arithmetic reference model.
module tb_mem_writeback;
    localparam int TIMEOUT = 255;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_ppl, alu_ppl, rdata2_ppl, instruction_ppl;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] wdata;
    logic        reg_wr, stall, bus_err, misalign;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [2:0] ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3[3] = '{3'b000, 3'b001, 3'b010};
    logic [4:0] alu_ops[7] = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_BRANCH};

    mem_writeback #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .pc_ppl(pc_ppl), .alu_ppl(alu_ppl), .rdata2_ppl(rdata2_ppl),
        .instruction_ppl(instruction_ppl),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wdata(wdata), .reg_wr(reg_wr), .stall(stall), .bus_err(bus_err),
        .misalign(misalign), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [1:0] off);
        int sz, start;
        logic [3:0] b;
        if (!st) return 4'hF;
        sz = acc_size(f3);
        start = (sz == 1) ? int'(off) : (sz == 2) ? (int'(off) & 2) : 0;
        b = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= start && i < start + sz) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_sdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz;
        logic [31:0] d;
        sz = acc_size(f3);
        d = 32'd0;
        for (int i = 0; i < 4; i++) d = d | (((rs2 >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        longint v;
        int sz;
        sz = acc_size(f3);
        if (sz == 4) return rdata;
        v = longint'(rdata >> (8 * int'(off))) % (longint'(1) << (8 * sz));
        if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] mk_instr(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        logic [16:0] hi;
        hi = 17'($urandom);
        return {hi, f3, rd, opc, 2'b11};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        instruction_ppl = NOP;
        dmem_gnt        = 1'b0;
        dmem_rvalid     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        instruction_ppl = mk_instr(OP_LOAD, 3'b010, 5'd6);
        alu_ppl = 32'h0000_1234; pc_ppl = 32'h40; rdata2_ppl = $urandom;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, reg_wr, stall, bus_err, misalign} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {dmem_req, dmem_we, dmem_be, reg_wr, stall, bus_err, misalign}); end
        checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
        checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", dmem_addr); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        set_nop();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_ops();
        logic [4:0] opc, rd;
        logic [31:0] exp_wd;
        logic exp_wr;
        instruction_ppl = {12'h010, 5'd0, 3'b000, 5'd5, OP_OPIMM, 2'b11};
        alu_ppl = 32'h10; pc_ppl = $urandom;
        #1;
        checks++; if (wdata !== 32'h10) begin errors++; $display("FAIL addi_wdata: got %h expected 10", wdata); end
        checks++; if ({reg_wr, stall, dmem_req} !== 3'b100) begin errors++; $display("FAIL addi_ctrl: got %b expected 100", {reg_wr, stall, dmem_req}); end
        tick();
        for (int t = 0; t < 20; t++) begin
            opc = alu_ops[$urandom_range(0, 6)];
            rd  = 5'($urandom_range(0, 31));
            instruction_ppl = mk_instr(opc, 3'($urandom), rd);
            alu_ppl = $urandom; pc_ppl = $urandom;
            exp_wd = (opc == OP_JAL || opc == OP_JALR) ? pc_ppl + 32'd4 : alu_ppl;
            exp_wr = (rd != 5'd0) && (opc != OP_BRANCH);
            #1;
            checks++; if (wdata !== exp_wd) begin errors++; $display("FAIL alu_wdata op=%b: got %h expected %h", opc, wdata, exp_wd); end
            checks++; if ({reg_wr, stall, dmem_req} !== {exp_wr, 2'b00}) begin
                errors++; $display("FAIL alu_ctrl op=%b rd=%0d: got %b expected %b", opc, rd, {reg_wr, stall, dmem_req}, {exp_wr, 2'b00}); end
            tick();
        end
        set_nop();
    endtask

    task automatic test_jal();
        pc_ppl = 32'h40; alu_ppl = $urandom;
        instruction_ppl = {20'h00000, 5'd1, OP_JAL, 2'b11};
        #1;
        checks++; if (wdata !== 32'h44) begin errors++; $display("FAIL jal_wdata: got %h expected 44", wdata); end
        checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL jal_wr: got %b expected 1", reg_wr); end
        tick();
        instruction_ppl = {20'h00000, 5'd0, OP_JAL, 2'b11};
        #1;
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL jal_x0_wr: got %b expected 0", reg_wr); end
        tick();
        set_nop();
    endtask

    task automatic test_load_byte();
        int stalls = 0;
        instruction_ppl = {12'h000, 5'd0, 3'b000, 5'd6, OP_LOAD, 2'b11};
        alu_ppl = 32'h103; pc_ppl = $urandom;
        for (int c = 0; c <= 3; c++) begin
            dmem_gnt = (c == 2); dmem_rvalid = (c == 3);
            dmem_rdata = (c == 3) ? 32'h80AA_BBCC : $urandom;
            #1;
            if (stall === 1'b1) stalls++;
            if (c <= 2) begin
                checks++; if ({dmem_req, dmem_we, reg_wr} !== 3'b100 || dmem_addr !== 32'h100) begin
                    errors++; $display("FAIL lb_req c=%0d: got req/we/wr=%b addr=%h expected 100 addr=100", c, {dmem_req, dmem_we, reg_wr}, dmem_addr); end
            end else begin
                checks++; if (wdata !== 32'hFFFF_FF80 || reg_wr !== 1'b1 || dmem_req !== 1'b0) begin
                    errors++; $display("FAIL lb_done: got wdata=%h wr=%b req=%b expected ffffff80 1 0", wdata, reg_wr, dmem_req); end
            end
            tick();
        end
        checks++; if (stalls != 3) begin errors++; $display("FAIL lb_stall_cycles: got %0d expected 3", stalls); end
        set_nop();
        #1;
        checks++; if ({reg_wr, stall} !== 2'b00) begin errors++; $display("FAIL lb_after: got %b expected 00", {reg_wr, stall}); end
        tick();
    endtask

    task automatic test_store_half();
        instruction_ppl = {7'h00, 5'd3, 5'd0, 3'b001, 5'd0, OP_STORE, 2'b11};
        alu_ppl = 32'h202; rdata2_ppl = 32'h1234_ABCD; dmem_gnt = 1'b1;
        #1;
        checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", dmem_be); end
        checks++; if (dmem_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", dmem_wdata); end
        checks++; if ({dmem_req, dmem_we, stall, reg_wr} !== 4'b1100 || dmem_addr !== 32'h200) begin
            errors++; $display("FAIL sh_ctrl: got %b addr=%h expected 1100 addr=200", {dmem_req, dmem_we, stall, reg_wr}, dmem_addr); end
        tick();
        set_nop();
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++; $display("FAIL sh_after: got %b expected 00", {dmem_req, stall}); end
        tick();
    endtask

    task automatic test_random_mem(input int n);
        logic st;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [31:0] a, rs2, rword, exp_wd;
        int gd, rvd, total, sz;
        for (int t = 0; t < n; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            rd = 5'($urandom_range(0, 31));
            a  = $urandom;
            sz = acc_size(f3);
`ifdef MISALIGN_TRAP_EN
            if (sz == 2) a[0] = 1'b0;
            if (sz == 4) a[1:0] = 2'b00;
`endif
            rs2 = $urandom; rword = $urandom;
            gd = $urandom_range(0, 3); rvd = $urandom_range(1, 3);
            total = st ? gd : gd + rvd;
            if (!st) exp_q.push_back(m_load(f3, a[1:0], rword));
            instruction_ppl = mk_instr(st ? OP_STORE : OP_LOAD, f3, rd);
            alu_ppl = a; rdata2_ppl = rs2; pc_ppl = $urandom;
            for (int c = 0; c <= total; c++) begin
                dmem_gnt = (c == gd);
                dmem_rvalid = !st && (c == total);
                dmem_rdata = (c == total) ? rword : $urandom;
                #1;
                checks++; if (dmem_req !== 1'(c <= gd)) begin errors++; $display("FAIL rnd_req t=%0d c=%0d: got %b expected %b", t, c, dmem_req, c <= gd); end
                if (c <= gd) begin
                    checks++; if (dmem_addr !== {a[31:2], 2'b00} || dmem_be !== m_be(st, f3, a[1:0]) || dmem_we !== st) begin
                        errors++; $display("FAIL rnd_bus t=%0d: got addr=%h be=%b we=%b expected %h %b %b", t, dmem_addr, dmem_be, dmem_we, {a[31:2], 2'b00}, m_be(st, f3, a[1:0]), st); end
                    if (st) begin
                        checks++; if (dmem_wdata !== m_sdata(f3, rs2)) begin
                            errors++; $display("FAIL rnd_sdata t=%0d f3=%b: got %h expected %h", t, f3, dmem_wdata, m_sdata(f3, rs2)); end
                    end
                end
                checks++; if (stall !== 1'(c != total)) begin errors++; $display("FAIL rnd_stall t=%0d c=%0d: got %b expected %b", t, c, stall, c != total); end
                if (!st && c == total) begin
                    exp_wd = exp_q.pop_front();
                    checks++; if (wdata !== exp_wd || reg_wr !== (rd != 5'd0)) begin
                        errors++; $display("FAIL rnd_load t=%0d f3=%b: got %h wr=%b expected %h wr=%b", t, f3, wdata, reg_wr, exp_wd, rd != 5'd0); end
                end else begin
                    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rnd_wr t=%0d c=%0d: got 1 expected 0", t, c); end
                end
                tick();
            end
        end
        set_nop();
    endtask

    task automatic test_timeout();
        int waited = 0;
        logic got = 1'b0;
        logic [2:0] at_err;
        instruction_ppl = {12'h000, 5'd0, 3'b010, 5'd7, OP_LOAD, 2'b11};
        alu_ppl = 32'h0000_0800; dmem_gnt = 1'b1;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b11) begin errors++; $display("FAIL to_issue: got %b expected 11", {dmem_req, stall}); end
        tick();
        dmem_gnt = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            #1;
            if (bus_err === 1'b1) begin
                got = 1'b1;
                at_err = {stall, reg_wr, dmem_req};
            end else begin
                if (stall === 1'b1) waited++;
                tick();
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_seen: got no bus_err expected bus_err within 400 cycles"); end
        checks++; if (waited != TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", waited, TIMEOUT); end
        checks++; if (at_err !== 3'b000) begin errors++; $display("FAIL to_abort: got stall/wr/req=%b expected 000", at_err); end
        tick();
        instruction_ppl = {12'h000, 5'd0, 3'b000, 5'd5, OP_OPIMM, 2'b11};
        alu_ppl = 32'h55;
        #1;
        checks++; if ({bus_err, stall, reg_wr} !== 3'b001 || wdata !== 32'h55) begin
            errors++; $display("FAIL to_after: got err/stall/wr=%b wdata=%h expected 001 55", {bus_err, stall, reg_wr}, wdata); end
        tick();
        set_nop();
    endtask

    task automatic test_reserved();
        instruction_ppl = mk_instr(OP_LOAD, 3'b011, 5'd4);
        dmem_gnt = 1'($urandom_range(0, 1));
        #1;
        checks++; if ({dmem_req, stall, reg_wr} !== 3'b000) begin errors++; $display("FAIL rsv_load: got %b expected 000", {dmem_req, stall, reg_wr}); end
        tick();
        instruction_ppl = mk_instr(OP_STORE, 3'b100, 5'd4);
        #1;
        checks++; if ({dmem_req, stall, reg_wr} !== 3'b000) begin errors++; $display("FAIL rsv_store: got %b expected 000", {dmem_req, stall, reg_wr}); end
        tick();
        set_nop();
    endtask

    task automatic test_reset_in_wait();
        instruction_ppl = {12'h000, 5'd0, 3'b010, 5'd9, OP_LOAD, 2'b11};
        alu_ppl = 32'h0000_0400; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_wait: got stall=%b expected 1", stall); end
        rst = 1'b0;
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, reg_wr, stall, bus_err, misalign} !== 10'd0 || wdata !== 32'd0 || dmem_addr !== 32'd0) begin
            errors++; $display("FAIL rw_reset_outs: got ctrl=%b wdata=%h addr=%h expected 0 0 0",
                {dmem_req, dmem_we, dmem_be, reg_wr, stall, bus_err, misalign}, wdata, dmem_addr); end
        tick();
        rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        #1;
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rw_stray: got reg_wr=%b expected 0", reg_wr); end
        tick();
        #1;
        checks++; if ({reg_wr, stall} !== 2'b01) begin errors++; $display("FAIL rw_stray2: got wr/stall=%b expected 01", {reg_wr, stall}); end
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_0001;
        #1;
        checks++; if (reg_wr !== 1'b1 || wdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rw_resume: got wr=%b wdata=%h expected 1 cafe0001", reg_wr, wdata); end
        tick();
        set_nop();
    endtask

    task automatic test_misalign();
        instruction_ppl = {12'h000, 5'd0, 3'b010, 5'd8, OP_LOAD, 2'b11};
        alu_ppl = 32'h101; dmem_gnt = 1'b1;
        #1;
`ifdef MISALIGN_TRAP_EN
        checks++; if ({misalign, dmem_req, stall, reg_wr} !== 4'b1000) begin
            errors++; $display("FAIL mis_trap: got %b expected 1000", {misalign, dmem_req, stall, reg_wr}); end
        tick();
        set_nop();
        #1;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misalign); end
`else
        checks++; if ({misalign, dmem_req} !== 2'b01 || dmem_addr !== 32'h100) begin
            errors++; $display("FAIL mis_off: got mis/req=%b addr=%h expected 01 100", {misalign, dmem_req}, dmem_addr); end
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
        #1;
        checks++; if (wdata !== 32'h1122_3344 || reg_wr !== 1'b1) begin
            errors++; $display("FAIL mis_off_data: got %h wr=%b expected 11223344 1", wdata, reg_wr); end
        tick();
        set_nop();
`endif
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_nop();
        pc_ppl = 32'd0; alu_ppl = 32'd0; rdata2_ppl = 32'd0; dmem_rdata = 32'd0;
        test_reset();
        test_alu_ops();
        test_jal();
        test_load_byte();
        test_store_half();
        test_random_mem(40);
        test_timeout();
        test_reserved();
        test_reset_in_wait();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
